// File: rtl/clock_div_ctrl_if.sv
// Configuration and status bundle for clock_div_ctrl.
// The master side is the configuration logic; the slave side is the divider.
interface clock_div_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_en;
    logic             tick;
    logic             div_clk;
    logic             running;
    logic             pending;
    logic [WIDTH-1:0] cur_div;

    modport master (
        output cfg_valid, cfg_div, cfg_en,
        input  cfg_ready, tick, div_clk, running, pending, cur_div
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_en,
        output cfg_ready, tick, div_clk, running, pending, cur_div
    );
endinterface

// File: rtl/clock_div_ctrl.sv
// Programmable clock-enable divider. Produces a one-cycle tick every cur_div
// cycles and a 50% duty div_clk toggling on each tick. Start, stop and divisor
// changes received while running are parked in a shadow register and applied
// only at a falling tick, so div_clk never has a truncated phase.
module clock_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 1,
    parameter bit AUTO_START  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    clock_div_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_PEND = 2'b10
    } state_t;

    // A divisor of zero behaves as one.
    localparam logic [WIDTH-1:0] DEF_DIV_C =
        (DEFAULT_DIV < 1) ? WIDTH'(1'b1) : WIDTH'(DEFAULT_DIV);

    // Map a requested divisor of zero onto one.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        clamp_div = (d == '0) ? WIDTH'(1'b1) : d;
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cur_div;
    logic [WIDTH-1:0] r_shadow_div;
    logic             r_shadow_en;
    logic             r_div_clk;
    logic             r_tick;
    logic             r_running;
    logic             r_pending;
    logic             r_cfg_ready;

    logic             w_xfer;
    logic             w_wrap;
    logic             w_fall;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_tick_nxt;
    logic             w_div_clk_nxt;

    // Handshake uses only the registered ready, so no comb path from cfg_valid to outputs.
    assign w_xfer = bus.cfg_valid && r_cfg_ready;
    assign w_wrap = (r_cnt == (r_cur_div - WIDTH'(1'b1)));
    assign w_fall = w_wrap && r_div_clk;

    // Free-running counter step used in RUN and PEND.
    always_comb begin
        w_cnt_nxt     = r_cnt + WIDTH'(1'b1);
        w_tick_nxt    = 1'b0;
        w_div_clk_nxt = r_div_clk;
        if (w_wrap) begin
            w_cnt_nxt     = '0;
            w_tick_nxt    = 1'b1;
            w_div_clk_nxt = ~r_div_clk;
        end else begin
            w_cnt_nxt     = r_cnt + WIDTH'(1'b1);
            w_tick_nxt    = 1'b0;
            w_div_clk_nxt = r_div_clk;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= AUTO_START ? S_RUN : S_IDLE;
            r_running    <= AUTO_START;
            r_cnt        <= '0;
            r_cur_div    <= DEF_DIV_C;
            r_shadow_div <= '0;
            r_shadow_en  <= 1'b0;
            r_div_clk    <= 1'b0;
            r_tick       <= 1'b0;
            r_pending    <= 1'b0;
            r_cfg_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tick    <= 1'b0;
                    r_div_clk <= 1'b0;
                    r_cnt     <= '0;
                    if (w_xfer) begin
                        r_cur_div <= clamp_div(bus.cfg_div);
                        if (bus.cfg_en) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt     <= w_cnt_nxt;
                    r_tick    <= w_tick_nxt;
                    r_div_clk <= w_div_clk_nxt;
                    // A request landing on a falling tick still waits for the next one.
                    if (w_xfer) begin
                        r_shadow_div <= clamp_div(bus.cfg_div);
                        r_shadow_en  <= bus.cfg_en;
                        r_state      <= S_PEND;
                        r_pending    <= 1'b1;
                        r_cfg_ready  <= 1'b0;
                    end
                end
                S_PEND: begin
                    if (w_fall) begin
                        r_tick      <= 1'b1;
                        r_cnt       <= '0;
                        r_div_clk   <= 1'b0;
                        r_pending   <= 1'b0;
                        r_cfg_ready <= 1'b1;
                        if (r_shadow_en) begin
                            r_cur_div <= r_shadow_div;
                            r_state   <= S_RUN;
                        end else begin
                            r_state   <= S_IDLE;
                            r_running <= 1'b0;
                        end
                    end else begin
                        r_cnt     <= w_cnt_nxt;
                        r_tick    <= w_tick_nxt;
                        r_div_clk <= w_div_clk_nxt;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_running   <= 1'b0;
                    r_cnt       <= '0;
                    r_tick      <= 1'b0;
                    r_div_clk   <= 1'b0;
                    r_pending   <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cfg_ready = r_cfg_ready;
    assign bus.tick      = r_tick;
    assign bus.div_clk   = r_div_clk;
    assign bus.running   = r_running;
    assign bus.pending   = r_pending;
    assign bus.cur_div   = r_cur_div;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Bench for clock_div_ctrl: directed scenarios plus random configuration
// traffic, compared every cycle against an age-based behavioural model.
module tb_clock_div_ctrl;

    localparam int W   = 8;
    localparam int DEF = 7;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   obs_acc;

    clock_div_ctrl_if #(.WIDTH(W)) bus ();

    clock_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(DEF), .AUTO_START(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed output vector: ready, running, pending, tick, div_clk, cur_div
    logic [12:0] obs;
    assign obs = {bus.cfg_ready, bus.running, bus.pending, bus.tick, bus.div_clk, bus.cur_div};

    // Model: state 0=idle 1=run 2=pend; age = cycles since the current divisor epoch began.
    int m_state;
    int m_cur;
    int m_age;
    int m_sh_div;
    bit m_sh_en;
    bit m_tick;
    bit m_dclk;

    function automatic logic [12:0] exp_vec();
        logic [7:0] c;
        c = m_cur[7:0];
        return {m_state != 2, m_state != 0, m_state == 2, m_tick, m_dclk, c};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cur = DEF; m_age = 0;
        m_sh_div = 0; m_sh_en = 1'b0; m_tick = 1'b0; m_dclk = 1'b0;
    endtask

    task automatic model_edge();
        bit acc;
        int dq;
        int st;
        acc = bus.cfg_valid && (m_state != 2);
        dq  = (bus.cfg_div == 8'd0) ? 1 : int'(bus.cfg_div);
        st  = m_state;
        if (st == 0) begin
            m_tick = 1'b0;
            m_dclk = 1'b0;
            if (acc) begin
                m_cur = dq;
                if (bus.cfg_en) begin
                    m_state = 1;
                    m_age   = 0;
                end
            end
        end else begin
            m_age  = m_age + 1;
            m_tick = (m_age % m_cur) == 0;
            m_dclk = ((m_age / m_cur) % 2) == 1;
            if (st == 2 && (m_age % (2 * m_cur)) == 0) begin
                m_age = 0;
                if (m_sh_en) begin
                    m_cur   = m_sh_div;
                    m_state = 1;
                end else begin
                    m_state = 0;
                end
            end else if (st == 1 && acc) begin
                m_sh_div = dq;
                m_sh_en  = bus.cfg_en;
                m_state  = 2;
            end
        end
    endtask

    // Advance one clock: model sees pre-edge inputs, outputs sampled 1 ns after the edge.
    task automatic step();
        if (reset) begin
            if (bus.cfg_valid && bus.cfg_ready) obs_acc++;
            model_edge();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int d, input bit en);
        bus.cfg_valid = v;
        bus.cfg_div   = 8'(d);
        bus.cfg_en    = en;
    endtask

    // Bring the block into RUN with the requested divisor (stimulus only).
    task automatic go_run(input int d);
        int dq;
        bit done;
        dq = (d == 0) ? 1 : d;
        for (int i = 0; i < 40 && m_state == 2; i++) step();
        drive(1'b1, d, 1'b1);
        step();
        drive(1'b0, 0, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (m_state == 1 && m_cur == dq) begin
                done = 1'b1;
                break;
            end
            step();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL go_run_timeout got=%0d required=%0d", m_cur, dq);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL reset_initial got=%h required=%h", obs, exp_vec());
        end
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, 4, 1'b1);
        step();
        drive(1'b0, 0, 1'b0);
        for (int i = 0; i < 20 && !m_dclk; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL reset_prerun got=%h required=%h", obs, exp_vec());
            end
        end
        // Mid-cycle asynchronous reset with div_clk high
        #2 reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL reset_async got=%h required=%h", obs, exp_vec());
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL reset_release got=%h required=%h", obs, exp_vec());
            end
        end
    endtask

    task automatic test_start();
        int first;
        first = 0;
        drive(1'b1, 3, 1'b1);
        step();
        drive(1'b0, 0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            step();
            if (bus.tick && first == 0) first = k;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL start cyc=%0d got=%h required=%h", k, obs, exp_vec());
            end
        end
        total++;
        if (first !== 3) begin
            bad++;
            $display("FAIL start_latency got=%0d required=3", first);
        end
    endtask

    task automatic test_change();
        go_run(3);
        for (int i = 0; i < 10 && (m_dclk || m_tick); i++) step();
        drive(1'b1, 5, 1'b1);
        step();
        drive(1'b0, 0, 1'b0);
        total++;
        if (bus.pending !== 1'b1 || bus.cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL change_pending got=%b%b required=10", bus.pending, bus.cfg_ready);
        end
        for (int k = 0; k < 30; k++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL change cyc=%0d got=%h required=%h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_edge_transfer();
        int n;
        go_run(3);
        for (int i = 0; i < 20 && !(m_dclk && (m_age % 6) == 5); i++) step();
        drive(1'b1, 2, 1'b1);
        step();
        drive(1'b0, 0, 1'b0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n++;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL edge cyc=%0d got=%h required=%h", k, obs, exp_vec());
            end
            if (bus.cur_div == 8'd2) break;
        end
        total++;
        if (n !== 6) begin
            bad++;
            $display("FAIL edge_latency got=%0d required=6", n);
        end
    endtask

    task automatic test_stop();
        go_run(4);
        for (int i = 0; i < 10 && (m_dclk || m_tick); i++) step();
        drive(1'b1, 0, 1'b0);
        step();
        drive(1'b0, 0, 1'b0);
        for (int k = 0; k < 24; k++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL stop cyc=%0d got=%h required=%h", k, obs, exp_vec());
            end
        end
        total++;
        if (bus.running !== 1'b0 || bus.div_clk !== 1'b0 || bus.tick !== 1'b0) begin
            bad++;
            $display("FAIL stop_idle got=%b%b%b required=000", bus.running, bus.div_clk, bus.tick);
        end
    endtask

    task automatic test_div_zero();
        int acc0;
        go_run(0);
        for (int k = 0; k < 8; k++) begin
            step();
            total++;
            if (obs !== exp_vec() || bus.tick !== 1'b1) begin
                bad++;
                $display("FAIL div0 cyc=%0d got=%h required=%h", k, obs, exp_vec());
            end
        end
        acc0 = obs_acc;
        drive(1'b1, 3, 1'b1);
        step();
        for (int k = 0; k < 20 && bus.pending; k++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL hold_valid cyc=%0d got=%h required=%h", k, obs, exp_vec());
            end
        end
        drive(1'b0, 0, 1'b0);
        total++;
        if (obs_acc - acc0 !== 1) begin
            bad++;
            $display("FAIL hold_valid_count got=%0d required=1", obs_acc - acc0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 6), $urandom_range(0, 4) != 0);
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h required=%h", k, obs, exp_vec());
            end
        end
        drive(1'b0, 0, 1'b0);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        total = 0;
        bad = 0;
        obs_acc = 0;
        drive(1'b0, 0, 1'b0);
        model_reset();
        test_reset();
        test_start();
        test_change();
        test_edge_transfer();
        test_stop();
        test_div_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_div_ctrl.md
# clock_div_ctrl

Programmable clock-enable divider controller that replaces free-running divide-by-2 toggling with a runtime-configured divisor. It produces a one-cycle `tick` enable and a 50 %-duty `div_clk` from the system clock. It also sequences start, stop and divisor changes so they take effect only on whole `div_clk` periods. It sits between the configuration logic and every slow-domain consumer of a divided clock or clock enable.

## Interface
Parameters:
- `WIDTH`, 8: divisor width in bits.
- `DEFAULT_DIV`, 1: divisor loaded at reset.
- `AUTO_START`, 0: 1 means the block leaves reset in RUN with `DEFAULT_DIV`.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `cfg_valid`  input  1  configuration request.
- `cfg_ready`  output  1  configuration can be accepted.
- `cfg_div`  input  WIDTH  requested divisor D; 0 is treated as 1.
- `cfg_en`  input  1  1 means run with D; 0 means stop.
- `tick`  output  1  one-cycle pulse every D cycles while running.
- `div_clk`  output  1  toggles on every tick, giving a period of 2·D cycles.
- `running`  output  1  state is not IDLE.
- `pending`  output  1  an accepted config is waiting for a period boundary.
- `cur_div`  output  WIDTH  divisor currently in effect.

## Operation
- A transfer occurs on a rising edge where `cfg_valid && cfg_ready`.
- States:
  - IDLE: `cfg_ready`=1.
  - RUN: `cfg_ready`=1.
  - PEND: `cfg_ready`=0.
- Registers: `cnt` (WIDTH bits), `cur_div`, `shadow_div`, `shadow_en`, `div_clk`, `tick`, state.
- Counting in RUN/PEND:
  - If `cnt == cur_div-1`: `cnt`←0, `tick`←1, `div_clk`←~`div_clk`.
  - Otherwise: `cnt`←`cnt`+1, `tick`←0.
- Falling tick: a tick edge where `div_clk` is 1 before the edge, i.e. it goes 1→0. This is the only point where a pending config is applied.
- IDLE + transfer, `cfg_en`=1: `cur_div`←max(D,1), `cnt`←0, `div_clk` stays 0, go to RUN.
- IDLE + transfer, `cfg_en`=0: `cur_div`←max(D,1), stay in IDLE.
- IDLE without transfer: `tick`=0, `div_clk`=0, `cnt` holds 0.
- RUN + transfer: `shadow`←{`cfg_en`, max(D,1)}, go to PEND. Counting continues with the old `cur_div`.
- PEND at a falling tick, `shadow_en`=1: `cur_div`←`shadow_div`, `cnt`←0, go to RUN. `tick` and the `div_clk` 1→0 toggle still occur on this edge.
- PEND at a falling tick, `shadow_en`=0: go to IDLE, `cnt`←0, `div_clk`←0, `tick`←1 for this final edge.
- A transfer on the same edge as a falling tick while in RUN is captured into PEND. It is applied at the *next* falling tick, never the current one.
- A rising tick (0→1) never applies a config, so `div_clk` never has a truncated high or low phase.
- `cur_div` never changes while `div_clk` is 1.

## Timing
- Reset asserted (asynchronous), with `AUTO_START`=0:
  - State IDLE, `cnt`=0, `cur_div`=`DEFAULT_DIV`.
  - `tick`=0, `div_clk`=0, `cfg_ready`=1, `running`=0, `pending`=0.
  - Shadow registers cleared.
- `AUTO_START`=1: same values, except state=RUN and `running`=1.
- Reset deassertion is taken synchronously on the next edge, as in the codebase. Reset mid-operation aborts everything immediately, including any PEND config.
- Start latency: transfer at edge E in IDLE gives the first `tick` high in the cycle after edge E+D. `div_clk` rises on that same edge.
- Tick spacing: exactly D cycles. D=1 gives `tick` continuously high and `div_clk` toggling every cycle.
- Change latency: from the transfer, the new divisor applies at the first falling tick strictly after the transfer edge. Worst case is 2·D_old cycles.
- `pending`=1 exactly while in PEND. `cfg_ready` is the registered complement of `pending`; there is no combinational path from `cfg_valid`.
- All outputs are registered.

## Test plan
- Reset while running with D=4, `div_clk`=1 → all outputs at reset values in the same cycle, with no clock edge needed; after release, IDLE with `cur_div`=`DEFAULT_DIV`.
- Start D=3 from IDLE → first tick 3 cycles after the transfer, ticks every 3 cycles, `div_clk` period 6 cycles at 50 % duty.
- RUN at D=3, transfer D=5 while `div_clk`=0 → `pending`=1 and `cfg_ready`=0. Old spacing continues through the rising tick. The switch happens at the falling tick, followed by a 10-cycle `div_clk` period.
- Transfer D=2 on the exact edge of a falling tick → applied at the following falling tick (6 cycles later for D_old=3), not the current one.
- Stop (`cfg_en`=0) while `div_clk`=0 → one more full high phase, then IDLE with `div_clk`=0, `running`=0 and no further ticks.
- `cfg_div`=0 with `cfg_en`=1 → `cur_div`=1, `tick` continuously high, `div_clk` toggling every cycle. `cfg_valid` held high during PEND → exactly one transfer accepted.
